// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared types and helpers for the MEM-stage access controller.
//   mac_state_t : controller state encoding (IDLE, PTR, DATA, DONE)
//   mask_w()    : number of byte lanes in a data word
//   ofs_w()     : width of the byte offset inside a data word
// No ports (package).
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } mac_state_t;

    function automatic int mask_w(input int width);
        return width / 8;
    endfunction

    function automatic int ofs_w(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the pipeline-side request/response signals and the D-cache bus of the
// MEM-stage access controller.
//   Pipeline side : req_read, req_write, req_indirect, req_byte, req_addr,
//                   req_wdata, flush (to controller); stall, rdata (from it)
//   D-cache side  : mem_address, mem_read, mem_write, mem_byte_enable,
//                   mem_wdata (from controller); mem_rdata, mem_resp (to it)
//   misalign      : present only when MEM_ACCESS_CTRL_MISALIGN_TRAP_EN is defined
// Modports: slave = the controller, master = the surrounding pipeline/cache.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
);
    import lc3b_types::*;

    localparam int MASK_W = mask_w(WIDTH);

    logic              req_read;
    logic              req_write;
    logic              req_indirect;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              flush;
    logic              stall;
    logic [WIDTH-1:0]  rdata;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    logic              misalign;
`endif
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [MASK_W-1:0] mem_byte_enable;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_resp;

    modport slave (
        input  req_read, req_write, req_indirect, req_byte, req_addr, req_wdata, flush,
        output stall, rdata,
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        output misalign,
`endif
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output req_read, req_write, req_indirect, req_byte, req_addr, req_wdata, flush,
        input  stall, rdata,
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        input  misalign,
`endif
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/byte_lane.sv
// -----------------------------------------------------------------------------
// byte_lane
// Byte-lane steering between the pipeline and the D-cache.
//   ofs_i       : byte offset within the word (low address bits)
//   byte_i      : 1 = byte access, 0 = word access
//   active_i    : a cache strobe is asserted this cycle (mask is 0 otherwise)
//   wdata_i     : store data from the pipeline
//   mem_rdata_i : read data from the D-cache
//   mask_o      : byte enables (one-hot for bytes, all ones for words)
//   mem_wdata_o : store data with the low byte replicated to every lane for bytes
//   rdata_o     : load data, selected byte zero-extended for byte loads
// -----------------------------------------------------------------------------
module byte_lane
    import lc3b_types::*;
#(
    parameter  int WIDTH  = 16,
    localparam int MASK_W = mask_w(WIDTH),
    localparam int OFS_W  = ofs_w(WIDTH)
) (
    input  logic [OFS_W-1:0]  ofs_i,
    input  logic              byte_i,
    input  logic              active_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [WIDTH-1:0]  mem_rdata_i,
    output logic [MASK_W-1:0] mask_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    output logic [WIDTH-1:0]  rdata_o
);

    always_comb begin
        mask_o = '0;
        if (active_i) begin
            mask_o = byte_i ? (MASK_W'(1) << ofs_i) : '1;
        end
    end

    // The cache picks the lane from the byte enable, so every lane carries the byte.
    assign mem_wdata_o = byte_i ? {MASK_W{wdata_i[7:0]}} : wdata_i;

    always_comb begin
        rdata_o = mem_rdata_i;
        if (byte_i) begin
            rdata_o = {{(WIDTH-8){1'b0}}, mem_rdata_i[{ofs_i, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage load/store controller: turns one pipeline request (direct or through
// a pointer, byte or word) into one or two D-cache transactions and stalls the
// pipeline until the result is ready.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_access_ctrl_if.slave (pipeline request/response + D-cache bus)
// Optional feature: define MEM_ACCESS_CTRL_MISALIGN_TRAP_EN to trap misaligned
// word accesses (no cache access, one-cycle misalign pulse). Without it the low
// address bits of word accesses are forced to zero.
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic clk,
    input  logic reset,
    mem_access_ctrl_if.slave bus
);

    localparam int OFS_W = ofs_w(WIDTH);

    mac_state_t        state_q;
    logic              read_q, write_q, ind_q, byte_q, abort_q;
    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] addr_q, ptr_q;
    logic [WIDTH-1:0]  wdata_q, rdata_q;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    logic              misalign_q;
`endif

    logic [ADDR_W-1:0] eff_addr;
    logic              word_acc;
    logic [WIDTH-1:0]  lane_rdata;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        r[OFS_W-1:0] = '0;
        return r;
    endfunction

`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
        return |a[OFS_W-1:0];
    endfunction
`endif

    // Request fields are captured in IDLE, so later changes on req_* cannot
    // disturb a transaction already in flight. A flush only sets abort_q; the
    // cache strobe stays up until its response so no cache request is orphaned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            ind_q       <= 1'b0;
            byte_q      <= 1'b0;
            abort_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            ptr_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if ((bus.req_read | bus.req_write) & ~bus.flush) begin
                        read_q  <= bus.req_read;
                        write_q <= bus.req_write;
                        ind_q   <= bus.req_indirect;
                        byte_q  <= bus.req_byte;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        abort_q <= 1'b0;
                        if (bus.req_indirect) begin
                            state_q    <= PTR;
                            mem_read_q <= 1'b1;
                        end
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
                        else if (!bus.req_byte && is_misaligned(bus.req_addr)) begin
                            state_q    <= DONE;
                            misalign_q <= 1'b1;
                        end
`endif
                        else begin
                            state_q     <= DATA;
                            mem_read_q  <= bus.req_read;
                            mem_write_q <= bus.req_write;
                        end
                    end
                end
                PTR: begin
                    if (bus.flush) abort_q <= 1'b1;
                    if (bus.mem_resp) begin
                        ptr_q      <= bus.mem_rdata[ADDR_W-1:0];
                        mem_read_q <= 1'b0;
                        if (abort_q | bus.flush) begin
                            state_q <= IDLE;
                            abort_q <= 1'b0;
                        end
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
                        else if (!byte_q && is_misaligned(bus.mem_rdata[ADDR_W-1:0])) begin
                            state_q    <= DONE;
                            misalign_q <= 1'b1;
                        end
`endif
                        else begin
                            state_q     <= DATA;
                            mem_read_q  <= read_q;
                            mem_write_q <= write_q;
                        end
                    end
                end
                DATA: begin
                    if (bus.flush) abort_q <= 1'b1;
                    if (bus.mem_resp) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (abort_q | bus.flush) begin
                            state_q <= IDLE;
                            abort_q <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            if (read_q) rdata_q <= lane_rdata;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
                    misalign_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The pointer fetch is always a full word; only the DATA phase of a byte
    // access keeps the low address bits.
    always_comb begin
        eff_addr = (state_q == DATA && ind_q) ? ptr_q : addr_q;
        word_acc = (state_q != DATA) | ~byte_q;
    end

    byte_lane #(.WIDTH(WIDTH)) u_byte_lane (
        .ofs_i       (eff_addr[OFS_W-1:0]),
        .byte_i      (byte_q & (state_q == DATA)),
        .active_i    (mem_read_q | mem_write_q),
        .wdata_i     (wdata_q),
        .mem_rdata_i (bus.mem_rdata),
        .mask_o      (bus.mem_byte_enable),
        .mem_wdata_o (bus.mem_wdata),
        .rdata_o     (lane_rdata)
    );

    assign bus.mem_address = word_acc ? word_align(eff_addr) : eff_addr;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.rdata       = rdata_q;
    assign bus.stall       = (bus.req_read | bus.req_write) & (state_q != DONE)
                             & ~bus.flush & ~reset;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    assign bus.misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl (WIDTH=16, ADDR_W=16). A vector table
// drives complete accesses while the bench plays the D-cache; expected load
// results go through a scoreboard queue. Hand-written sequences cover reset,
// flush and the misaligned-word behaviour (both builds of
// MEM_ACCESS_CTRL_MISALIGN_TRAP_EN).
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] sb_q[$];
    logic [15:0] model_rdata = 16'h0000;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, ind, byt;
        logic [15:0] addr, wdata, ptr_data, mem_data;
        int          delay;
        logic [15:0] exp_addr;
        logic [1:0]  exp_mask;
        logic [15:0] exp_wdata, exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic ind, input logic byt,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] ptr_data, input logic [15:0] mem_data,
                                input int delay, input logic [15:0] exp_addr,
                                input logic [1:0] exp_mask, input logic [15:0] exp_wdata,
                                input logic [15:0] exp_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ind = ind; v.byt = byt;
        v.addr = addr; v.wdata = wdata; v.ptr_data = ptr_data; v.mem_data = mem_data;
        v.delay = delay; v.exp_addr = exp_addr; v.exp_mask = exp_mask;
        v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drop_req();
        bus.req_read = 1'b0; bus.req_write = 1'b0; bus.req_indirect = 1'b0;
        bus.req_byte = 1'b0; bus.mem_resp = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic check_idle_bus(input string name);
        check({name, ".strobes"}, 32'({bus.mem_read, bus.mem_write}), 32'd0);
    endtask

    // Runs one complete access, acting as the D-cache: each phase answers after
    // v.delay strobe cycles.
    task automatic run_vec(input vec_t v, input string nm);
        int st_cnt = 0;
        int strobe_cnt = 0;
        int ph = 0;
        int seen = 0;
        int phases;
        logic done = 1'b0;
        logic [15:0] exp_rd;
        phases = v.ind ? 2 : 1;
        sb_q.push_back(v.exp_rdata);
        @(negedge clk);
        bus.req_read = v.rd; bus.req_write = v.wr; bus.req_indirect = v.ind;
        bus.req_byte = v.byt; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            bus.mem_resp = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
                strobe_cnt++;
                if (seen == 0) begin
                    if (v.ind && ph == 0) begin
                        check({nm, ".ptr_rdwr"}, 32'({bus.mem_read, bus.mem_write}), 32'b10);
                        check({nm, ".ptr_addr"}, 32'(bus.mem_address), 32'(v.addr & 16'hFFFE));
                        check({nm, ".ptr_mask"}, 32'(bus.mem_byte_enable), 32'b11);
                    end else begin
                        check({nm, ".rdwr"}, 32'({bus.mem_read, bus.mem_write}), 32'({v.rd, v.wr}));
                        check({nm, ".addr"}, 32'(bus.mem_address), 32'(v.exp_addr));
                        check({nm, ".mask"}, 32'(bus.mem_byte_enable), 32'(v.exp_mask));
                        if (v.wr) check({nm, ".wdata"}, 32'(bus.mem_wdata), 32'(v.exp_wdata));
                    end
                end
                seen++;
                if (seen == v.delay) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = (v.ind && ph == 0) ? v.ptr_data : v.mem_data;
                    ph++;
                    seen = 0;
                end
            end
            #1;
            if (bus.stall) begin
                st_cnt++;
            end else begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    check({nm, ".sb_empty"}, 32'd1, 32'd0);
                end else begin
                    exp_rd = sb_q.pop_front();
                    check({nm, ".rdata"}, 32'(bus.rdata), 32'(exp_rd));
                end
            end
        end
        check({nm, ".completed"}, 32'(done), 32'd1);
        check({nm, ".stall_cycles"}, 32'(st_cnt), 32'(1 + phases * v.delay));
        check({nm, ".strobe_cycles"}, 32'(strobe_cnt), 32'(phases * v.delay));
        model_rdata = v.exp_rdata;
        @(negedge clk);
        drop_req();
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Fields: rd wr ind byt addr wdata ptr_data mem_data delay exp_addr exp_mask exp_wdata exp_rdata
        vecs.push_back(mk(1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'hBEEF, 3, 16'h0040, 2'b11, 16'h0000, 16'hBEEF));
        vecs.push_back(mk(0, 1, 0, 1, 16'h0041, 16'h12AB, 16'h0000, 16'h0000, 1, 16'h0041, 2'b10, 16'hABAB, 16'hBEEF));
        vecs.push_back(mk(1, 0, 1, 0, 16'h0100, 16'h0000, 16'h3000, 16'h5A5A, 2, 16'h3000, 2'b11, 16'h0000, 16'h5A5A));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0205, 16'h0000, 16'h0000, 16'h7788, 1, 16'h0205, 2'b10, 16'h0000, 16'h0077));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0204, 16'h0000, 16'h0000, 16'h7788, 2, 16'h0204, 2'b01, 16'h0000, 16'h0088));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0300, 16'hCAFE, 16'h0000, 16'h0000, 2, 16'h0300, 2'b11, 16'hCAFE, 16'h0088));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0400, 16'h1234, 16'h0500, 16'h0000, 1, 16'h0500, 2'b11, 16'h1234, 16'h0088));
        vecs.push_back(mk(0, 1, 0, 1, 16'h0600, 16'h00C3, 16'h0000, 16'h0000, 1, 16'h0600, 2'b01, 16'hC3C3, 16'h0088));

        reset = 1'b1;
        drop_req();
        bus.req_addr = 16'h0000; bus.req_wdata = 16'h0000; bus.mem_rdata = 16'h0000;

        // Reset state, with a request pending to show stall is held low
        @(negedge clk);
        bus.req_read = 1'b1;
        #1;
        check("reset.stall", 32'(bus.stall), 32'd0);
        check_idle_bus("reset");
        check("reset.rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drop_req();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush while waiting for the pointer: read held until the response,
        // then back to IDLE with no data access.
        @(negedge clk);
        bus.req_read = 1'b1; bus.req_indirect = 1'b1; bus.req_addr = 16'h0100;
        @(negedge clk);
        check("flush_ptr.read_c1", 32'(bus.mem_read), 32'd1);
        bus.flush = 1'b1; bus.req_read = 1'b0; bus.req_indirect = 1'b0;
        #1;
        check("flush_ptr.stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ptr.read_held", 32'(bus.mem_read), 32'd1);
        check("flush_ptr.addr_held", 32'(bus.mem_address), 32'h0100);
        @(negedge clk);
        check("flush_ptr.read_c3", 32'(bus.mem_read), 32'd1);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h3000;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check_idle_bus("flush_ptr.after_resp");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_idle_bus("flush_ptr.no_data");
        end
        check("flush_ptr.rdata", 32'(bus.rdata), 32'(model_rdata));

        // Flush arriving together with the data response: result discarded.
        @(negedge clk);
        bus.req_read = 1'b1; bus.req_addr = 16'h0600;
        @(negedge clk);
        check("flush_data.read", 32'(bus.mem_read), 32'd1);
        bus.flush = 1'b1; bus.mem_resp = 1'b1; bus.mem_rdata = 16'h9999; bus.req_read = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0; bus.mem_resp = 1'b0;
        check_idle_bus("flush_data.after");
        #1;
        check("flush_data.rdata", 32'(bus.rdata), 32'(model_rdata));
        @(negedge clk);
        check_idle_bus("flush_data.no_retry");

        // Misaligned word access
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        @(negedge clk);
        bus.req_read = 1'b1; bus.req_addr = 16'h0003;
        #1;
        check("mis.stall_idle", 32'(bus.stall), 32'd1);
        @(negedge clk);
        check_idle_bus("mis.done");
        check("mis.pulse", 32'(bus.misalign), 32'd1);
        #1;
        check("mis.stall_done", 32'(bus.stall), 32'd0);
        check("mis.rdata", 32'(bus.rdata), 32'(model_rdata));
        drop_req();
        @(negedge clk);
        check("mis.pulse_end", 32'(bus.misalign), 32'd0);
        check_idle_bus("mis.after");
`else
        run_vec(mk(1, 0, 0, 0, 16'h0003, 16'h0000, 16'h0000, 16'h4321, 1, 16'h0002, 2'b11, 16'h0000, 16'h4321), "mis_direct");
        run_vec(mk(1, 0, 1, 0, 16'h0110, 16'h0000, 16'h3001, 16'h1111, 1, 16'h3000, 2'b11, 16'h0000, 16'h1111), "mis_indirect");
`endif

        // Reset in the middle of a data access, then a stray response in IDLE.
        @(negedge clk);
        bus.req_read = 1'b1; bus.req_addr = 16'h0700;
        @(negedge clk);
        check("rst_mid.read", 32'(bus.mem_read), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_bus("rst_mid.async");
        check("rst_mid.stall", 32'(bus.stall), 32'd0);
        check("rst_mid.rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.req_read = 1'b0;
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'hFFFF;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check_idle_bus("stray_resp");
        #1;
        check("stray_resp.stall", 32'(bus.stall), 32'd0);
        check("stray_resp.rdata", 32'(bus.rdata), 32'd0);

        run_vec(mk(1, 0, 0, 0, 16'h0042, 16'h0000, 16'h0000, 16'h0F0F, 2, 16'h0042, 2'b11, 16'h0000, 16'h0F0F), "post_reset");

        check("sb.drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
